// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: VGA raster timing generator that walks the VRAM read port in raster order
// and drives registered sync/RGB plus a one-clock vertical-blank pulse.
module vga_frame_scanner #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int H_FRONT = 16,
    parameter int H_SYNC = 96,
    parameter int H_BACK = 48,
    parameter int V_FRONT = 10,
    parameter int V_SYNC = 2,
    parameter int V_BACK = 33,
    parameter int ADDR_WIDTH = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH = 1,
    parameter logic [11:0] FG_COLOR = 12'hEC6,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  pixel_tick_i,
    input  logic [DATA_WIDTH-1:0] vram_rd_data_i,
    output logic [ADDR_WIDTH-1:0] vram_rd_address_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  video_on_o,
    output logic [11:0]           rgb_o,
    output logic                  vblank_start_o
);
    localparam int H_TOTAL = ACTIVE_COLUMNS + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_ACT = HW'(ACTIVE_COLUMNS);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_FIRST = HW'(ACTIVE_COLUMNS + H_FRONT);
    localparam logic [HW-1:0] HS_LAST = HW'(ACTIVE_COLUMNS + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_ACT = VW'(ACTIVE_ROWS);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(ACTIVE_ROWS - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(ACTIVE_ROWS + V_FRONT);
    localparam logic [VW-1:0] VS_LAST = VW'(ACTIVE_ROWS + V_FRONT + V_SYNC - 1);
    localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(ACTIVE_COLUMNS * ACTIVE_ROWS - 1);

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic active, h_last, v_last, v_enter;

    assign active = (h_count < H_ACT) && (v_count < V_ACT);
    assign h_last = h_count == H_LAST;
    assign v_last = v_count == V_LAST;
    assign v_enter = h_last && (v_count == V_ACT_LAST);

    // The pointer wraps after the final visible pixel so it never exposes an out-of-range address.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            h_count <= '0;
            v_count <= '0;
            vram_rd_address_o <= '0;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
            video_on_o <= 1'b0;
            rgb_o <= '0;
            vblank_start_o <= 1'b0;
        end else begin
            vblank_start_o <= pixel_tick_i && v_enter;
            if (pixel_tick_i) begin
                h_count <= h_last ? '0 : h_count + 1'b1;
                if (h_last)
                    v_count <= v_last ? '0 : v_count + 1'b1;
                vram_rd_address_o <= (v_enter || (active && vram_rd_address_o == A_LAST)) ? '0 :
                                     active ? vram_rd_address_o + 1'b1 : vram_rd_address_o;
                hsync_o <= !(h_count >= HS_FIRST && h_count <= HS_LAST);
                vsync_o <= !(v_count >= VS_FIRST && v_count <= VS_LAST);
                video_on_o <= active;
                rgb_o <= !active ? 12'h000 : (|vram_rd_data_i ? FG_COLOR : BG_COLOR);
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_scanner.sv
// tb_vga_frame_scanner: directed bench on a scaled-down 8x6 raster (15x10 total) so whole frames fit.
module tb_vga_frame_scanner;
    localparam int AC = 8, AR = 6, HT = 15, VT = 10;

    logic clk = 1'b0, reset = 1'b0, tick = 1'b0;
    logic [0:0] rd_data;
    logic [5:0] addr;
    logic hs, vs, von, vb;
    logic [11:0] rgb;
    int errors = 0, checks = 0;
    int h = 0, v = 0, ph = 0, pv = 0, bad_addr = 0;
    logic vb_now, vb_after;

    vga_frame_scanner #(
        .ACTIVE_COLUMNS(AC), .ACTIVE_ROWS(AR),
        .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut (
        .clk_i(clk), .reset_i(reset), .pixel_tick_i(tick),
        .vram_rd_data_i(rd_data), .vram_rd_address_o(addr),
        .hsync_o(hs), .vsync_o(vs), .video_on_o(von), .rgb_o(rgb),
        .vblank_start_o(vb)
    );

    always #5 clk = ~clk;

    // VRAM model: cell(h,v) = h[0], which equals address bit 0 since AC is even.
    always @(posedge clk) begin
        rd_data <= addr[0];
        if (reset && addr >= 6'd48) bad_addr++;
    end

    task automatic step();
        ph = h;
        pv = v;
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        vb_now = vb;
        @(negedge clk);
        vb_after = vb;
        @(negedge clk);
        h = (h == HT - 1) ? 0 : h + 1;
        if (ph == HT - 1) v = (v == VT - 1) ? 0 : v + 1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) tick = (i % 2 == 0);
            checks += 6;
            if (hs !== 1'b1) begin errors++; $display("FAIL reset_hsync act=%b exp=1", hs); end
            if (vs !== 1'b1) begin errors++; $display("FAIL reset_vsync act=%b exp=1", vs); end
            if (von !== 1'b0) begin errors++; $display("FAIL reset_video_on act=%b exp=0", von); end
            if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb act=%h exp=000", rgb); end
            if (addr !== 6'd0) begin errors++; $display("FAIL reset_addr act=%0d exp=0", addr); end
            if (vb !== 1'b0) begin errors++; $display("FAIL reset_vblank act=%b exp=0", vb); end
        end
        @(negedge clk) tick = 1'b0;
        reset = 1'b1;
        h = 0;
        v = 0;
    endtask

    task automatic test_first_line();
        logic [11:0] exp_rgb;
        for (int i = 0; i < HT; i++) begin
            if (h < AC) begin
                checks++;
                if (addr !== 6'(h)) begin errors++; $display("FAIL line0_addr h=%0d act=%0d exp=%0d", h, addr, h); end
            end
            step();
            exp_rgb = (ph < AC) ? ((ph % 2 == 1) ? 12'hEC6 : 12'h000) : 12'h000;
            checks += 2;
            if (rgb !== exp_rgb) begin errors++; $display("FAIL line0_rgb h=%0d act=%h exp=%h", ph, rgb, exp_rgb); end
            if (von !== (ph < AC)) begin errors++; $display("FAIL line0_video_on h=%0d act=%b exp=%b", ph, von, ph < AC); end
        end
        checks++;
        if (addr !== 6'd8) begin errors++; $display("FAIL line1_start_addr act=%0d exp=8", addr); end
    endtask

    task automatic test_frame(input int exp_ticks, input int exp_hs, input int exp_vs);
        int n = 0, hs_low = 0, vs_low = 0, vb_cnt = 0, exp_addr;
        logic act;
        logic [11:0] exp_rgb;
        do begin
            exp_addr = (v >= AR) ? 0 : (h < AC) ? v * AC + h : (v == AR - 1) ? 0 : (v + 1) * AC;
            checks++;
            if (addr !== 6'(exp_addr)) begin errors++; $display("FAIL frame_addr h=%0d v=%0d act=%0d exp=%0d", h, v, addr, exp_addr); end
            step();
            n++;
            act = (ph < AC) && (pv < AR);
            exp_rgb = act ? ((ph % 2 == 1) ? 12'hEC6 : 12'h000) : 12'h000;
            checks += 5;
            if (hs !== !(ph >= 10 && ph <= 12)) begin errors++; $display("FAIL frame_hsync h=%0d act=%b", ph, hs); end
            if (vs !== !(pv >= 7 && pv <= 8)) begin errors++; $display("FAIL frame_vsync v=%0d act=%b", pv, vs); end
            if (von !== act) begin errors++; $display("FAIL frame_video_on h=%0d v=%0d act=%b exp=%b", ph, pv, von, act); end
            if (rgb !== exp_rgb) begin errors++; $display("FAIL frame_rgb h=%0d v=%0d act=%h exp=%h", ph, pv, rgb, exp_rgb); end
            if (vb_after !== 1'b0) begin errors++; $display("FAIL vblank_width act=%b exp=0", vb_after); end
            if (!hs) hs_low++;
            if (!vs) vs_low++;
            if (vb_now === 1'b1) begin
                vb_cnt++;
                checks++;
                if (!(ph == HT - 1 && pv == AR - 1)) begin errors++; $display("FAIL vblank_pos act=(%0d,%0d) exp=(14,5)", ph, pv); end
            end
        end while (!(h == 0 && v == 0) && n < 200);
        checks += 5;
        if (n != exp_ticks) begin errors++; $display("FAIL frame_ticks act=%0d exp=%0d", n, exp_ticks); end
        if (hs_low != exp_hs) begin errors++; $display("FAIL hsync_low_count act=%0d exp=%0d", hs_low, exp_hs); end
        if (vs_low != exp_vs) begin errors++; $display("FAIL vsync_low_count act=%0d exp=%0d", vs_low, exp_vs); end
        if (vb_cnt != 1) begin errors++; $display("FAIL vblank_count act=%0d exp=1", vb_cnt); end
        if (bad_addr != 0) begin errors++; $display("FAIL addr_range act=%0d exp=0", bad_addr); end
    endtask

    task automatic test_stall();
        logic [5:0] s_addr;
        logic s_hs, s_vs, s_von;
        logic [11:0] s_rgb;
        int diffs = 0;
        for (int i = 0; i < 20; i++) step();
        s_addr = addr; s_hs = hs; s_vs = vs; s_von = von; s_rgb = rgb;
        checks += 2;
        if (addr !== 6'd13) begin errors++; $display("FAIL stall_addr act=%0d exp=13", addr); end
        if (rgb !== 12'h000 || von !== 1'b1) begin errors++; $display("FAIL stall_pre_pixel act=%h/%b exp=000/1", rgb, von); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (addr !== s_addr || hs !== s_hs || vs !== s_vs || von !== s_von || rgb !== s_rgb || vb !== 1'b0) diffs++;
        end
        checks++;
        if (diffs != 0) begin errors++; $display("FAIL stall_frozen act=%0d exp=0", diffs); end
        step();
        checks += 2;
        if (rgb !== 12'hEC6) begin errors++; $display("FAIL stall_resume_rgb act=%h exp=ec6", rgb); end
        if (addr !== 6'd14) begin errors++; $display("FAIL stall_resume_addr act=%0d exp=14", addr); end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!(h == 4 && v == 3) && guard < 200) begin
            step();
            guard++;
        end
        checks += 2;
        if (guard >= 200) begin errors++; $display("FAIL mid_reach act=%0d exp<200", guard); end
        if (rgb !== 12'hEC6 || addr !== 6'd28) begin errors++; $display("FAIL mid_pre act=%h/%0d exp=ec6/28", rgb, addr); end
        @(negedge clk) reset = 1'b0;
        tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        checks += 6;
        if (hs !== 1'b1) begin errors++; $display("FAIL mid_hsync act=%b exp=1", hs); end
        if (vs !== 1'b1) begin errors++; $display("FAIL mid_vsync act=%b exp=1", vs); end
        if (von !== 1'b0) begin errors++; $display("FAIL mid_video_on act=%b exp=0", von); end
        if (rgb !== 12'h000) begin errors++; $display("FAIL mid_rgb act=%h exp=000", rgb); end
        if (addr !== 6'd0) begin errors++; $display("FAIL mid_addr act=%0d exp=0", addr); end
        if (vb !== 1'b0) begin errors++; $display("FAIL mid_vblank act=%b exp=0", vb); end
        @(negedge clk) reset = 1'b1;
        h = 0;
        v = 0;
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frame(135, 27, 30);
        test_stall();
        test_reset_mid();
        test_frame(150, 30, 30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
